// File: rtl/ascon_phase_sched.sv
// Ascon phase sequencer: steps one AEAD or hash operation through its phases,
// pops one AD/TEXT block per absorb step, starts the permutation with the
// proper round count and raises the phase/domain strobes for the datapath.
// Handshake: a *_data_req_o pulse is issued only in a cycle after the matching
// *_empty_i was sampled low; perm_start_o is a one-cycle request and a
// perm_done_i pulse is accepted only while a permutation is outstanding and
// never in the same cycle as perm_start_o.
module ascon_phase_sched #(
  parameter int BLK_W     = 7,
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6,
  parameter int HASH_OUT  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [BLK_W-1:0] ad_blocks_i,
  input  logic [BLK_W-1:0] text_blocks_i,
  input  logic             ad_empty_i,
  input  logic             text_empty_i,
  input  logic             perm_done_i,
  output logic             ad_data_req_o,
  output logic             text_data_req_o,
  output logic             abs_ad_state_o,
  output logic             abs_text_state_o,
  output logic             init_domain_o,
  output logic             sep_domain_o,
  output logic             perm_start_o,
  output logic [3:0]       perm_rounds_o,
  output logic             squeeze_o,
  output logic             sqz_hash_done_o,
  output logic             tag_valid_o,
  output logic             busy_o,
  output logic [4:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ABS_AD, S_SEP, S_ABS_TXT, S_FINAL, S_SQZ, S_DONE
  } state_t;

  // Per-block substate; in SQZ, XOR means "a squeeze block was just emitted".
  typedef enum logic [1:0] {SUB_REQ, SUB_XOR, SUB_PERM} sub_t;

  localparam int              SQZ_W      = $clog2(HASH_OUT + 1);
  localparam logic [SQZ_W-1:0] HASH_OUT_L = SQZ_W'(HASH_OUT);
  localparam logic [3:0]      PA_R       = 4'(PA_ROUNDS);
  localparam logic [3:0]      PB_R       = 4'(PB_ROUNDS);

  state_t           r_state;
  sub_t             r_sub;
  logic             r_hash;
  logic [BLK_W-1:0] r_ad_blocks;
  logic [BLK_W-1:0] r_text_blocks;
  logic [BLK_W-1:0] r_cnt;
  logic [SQZ_W-1:0] r_sqz_cnt;

  logic [BLK_W-1:0] w_cnt_inc;
  logic [SQZ_W-1:0] w_sqz_inc;
  logic [BLK_W-1:0] w_ad_eff;
  logic [BLK_W-1:0] w_text_eff;
  logic             w_ad_last;
  logic             w_txt_last;
  logic             w_perm_ack;

  // Block counters, end-of-phase compares and start-time count fix-ups.
  always_comb begin
    w_cnt_inc  = r_cnt + BLK_W'(1);
    w_sqz_inc  = r_sqz_cnt + SQZ_W'(1);
    w_ad_last  = (w_cnt_inc == r_ad_blocks);
    w_txt_last = (w_cnt_inc == r_text_blocks);
    // A done pulse coinciding with our own start cannot be the answer to it.
    w_perm_ack = perm_done_i & ~perm_start_o;
    w_text_eff = (text_blocks_i == '0) ? BLK_W'(1) : text_blocks_i;
    w_ad_eff   = (mode_i[1] && (ad_blocks_i == '0)) ? BLK_W'(1) : ad_blocks_i;
  end

  assign dbg_state_o = {r_state, r_sub};

  // Phase FSM with all strobes registered alongside the state transition.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state          <= S_IDLE;
      r_sub            <= SUB_REQ;
      r_hash           <= 1'b0;
      r_ad_blocks      <= '0;
      r_text_blocks    <= '0;
      r_cnt            <= '0;
      r_sqz_cnt        <= '0;
      ad_data_req_o    <= 1'b0;
      text_data_req_o  <= 1'b0;
      abs_ad_state_o   <= 1'b0;
      abs_text_state_o <= 1'b0;
      init_domain_o    <= 1'b0;
      sep_domain_o     <= 1'b0;
      perm_start_o     <= 1'b0;
      perm_rounds_o    <= '0;
      squeeze_o        <= 1'b0;
      sqz_hash_done_o  <= 1'b0;
      tag_valid_o      <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      ad_data_req_o   <= 1'b0;
      text_data_req_o <= 1'b0;
      init_domain_o   <= 1'b0;
      sep_domain_o    <= 1'b0;
      perm_start_o    <= 1'b0;
      squeeze_o       <= 1'b0;
      sqz_hash_done_o <= 1'b0;
      tag_valid_o     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && (mode_i != 2'b11)) begin
            r_state       <= S_INIT;
            r_sub         <= SUB_REQ;
            r_hash        <= mode_i[1];
            r_ad_blocks   <= w_ad_eff;
            r_text_blocks <= w_text_eff;
            r_cnt         <= '0;
            r_sqz_cnt     <= '0;
            init_domain_o <= 1'b1;
            perm_start_o  <= 1'b1;
            perm_rounds_o <= PA_R;
            busy_o        <= 1'b1;
          end
        end
        S_INIT: begin
          if (w_perm_ack) begin
            if (r_hash || (r_ad_blocks != '0)) begin
              r_state        <= S_ABS_AD;
              r_sub          <= SUB_REQ;
              abs_ad_state_o <= 1'b1;
            end else begin
              r_state      <= S_SEP;
              sep_domain_o <= 1'b1;
            end
          end
        end
        S_ABS_AD: begin
          case (r_sub)
            SUB_REQ: begin
              if (!ad_empty_i) begin
                ad_data_req_o <= 1'b1;
                r_sub         <= SUB_XOR;
              end
            end
            SUB_XOR: begin
              perm_start_o  <= 1'b1;
              perm_rounds_o <= r_hash ? PA_R : PB_R;
              r_sub         <= SUB_PERM;
            end
            default: begin
              if (w_perm_ack) begin
                if (w_ad_last) begin
                  r_cnt          <= '0;
                  abs_ad_state_o <= 1'b0;
                  if (r_hash) begin
                    r_state         <= S_SQZ;
                    r_sub           <= SUB_XOR;
                    squeeze_o       <= 1'b1;
                    r_sqz_cnt       <= w_sqz_inc;
                    sqz_hash_done_o <= (w_sqz_inc == HASH_OUT_L);
                  end else begin
                    r_state      <= S_SEP;
                    sep_domain_o <= 1'b1;
                  end
                end else begin
                  r_cnt <= w_cnt_inc;
                  r_sub <= SUB_REQ;
                end
              end
            end
          endcase
        end
        S_SEP: begin
          r_state          <= S_ABS_TXT;
          r_sub            <= SUB_REQ;
          abs_text_state_o <= 1'b1;
        end
        S_ABS_TXT: begin
          case (r_sub)
            SUB_REQ: begin
              if (!text_empty_i) begin
                text_data_req_o <= 1'b1;
                r_sub           <= SUB_XOR;
              end
            end
            SUB_XOR: begin
              perm_start_o <= 1'b1;
              if (w_txt_last) begin
                // Last text block goes straight to finalization.
                r_state          <= S_FINAL;
                r_sub            <= SUB_REQ;
                r_cnt            <= '0;
                abs_text_state_o <= 1'b0;
                perm_rounds_o    <= PA_R;
              end else begin
                r_sub         <= SUB_PERM;
                perm_rounds_o <= PB_R;
              end
            end
            default: begin
              if (w_perm_ack) begin
                r_cnt <= w_cnt_inc;
                r_sub <= SUB_REQ;
              end
            end
          endcase
        end
        S_FINAL: begin
          if (w_perm_ack) begin
            tag_valid_o <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_SQZ: begin
          if (r_sub == SUB_PERM) begin
            if (w_perm_ack) begin
              squeeze_o       <= 1'b1;
              r_sqz_cnt       <= w_sqz_inc;
              sqz_hash_done_o <= (w_sqz_inc == HASH_OUT_L);
              r_sub           <= SUB_XOR;
            end
          end else if (r_sqz_cnt == HASH_OUT_L) begin
            r_state <= S_DONE;
            r_sub   <= SUB_REQ;
          end else begin
            perm_start_o  <= 1'b1;
            perm_rounds_o <= PA_R;
            r_sub         <= SUB_PERM;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_sub     <= SUB_REQ;
          r_sqz_cnt <= '0;
          busy_o    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_sub   <= SUB_REQ;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
